// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage with a valid/ready handshake.
// A main register drives execute, and a skid register absorbs one extra
// instruction while execute stalls. Because in_ready depends only on skid
// occupancy and flush, it never waits on out_ready.
// Flush squashes both entries. Control is gated to zero whenever the stage
// presents a bubble. Two saturating counters record stalls and bubbles.
module id_ex_pipe_stage #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cnt_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_opa,
  output logic [DATA_W-1:0] out_opb,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } ent_t;

  ent_t main_q, skid_q, in_ent;
  logic main_valid, skid_valid;
  logic acc, pop;

  assign in_ent   = '{ctrl: in_ctrl, imm: in_imm, opa: in_opa, opb: in_opb};
  assign in_ready = !skid_valid && !flush;
  assign acc      = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  // Two-entry elastic buffer. The skid is only ever filled while the main
  // register is full, so skid_valid implies main_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Squash only the valid bits; the data fields keep their last value.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (acc) begin
        main_valid <= 1'b1;
        main_q     <= in_ent;
      end
    end else if (!skid_valid) begin
      if (pop) begin
        main_valid <= acc;
        if (acc) main_q <= in_ent;
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_q     <= in_ent;
      end
    end else if (pop) begin
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end
  end

  // Outputs come from the main register. Control is zeroed on bubbles so
  // execute never acts on stale write or memory enables.
  always_comb begin
    out_valid = main_valid;
    out_ctrl  = main_valid ? main_q.ctrl : '0;
    out_imm   = main_q.imm;
    out_opa   = main_q.opa;
    out_opb   = main_q.opb;
  end

  // Saturating performance counters. A clear takes priority over an event
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (main_valid && !out_ready && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (!main_valid && bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Testbench for id_ex_pipe_stage. A small FIFO model and scoreboard
// predict the handshake, the output data and the counters on every cycle.
// A vector table and a set of directed sequences drive the corner cases,
// and a random phase follows them.
module tb_id_ex_pipe_stage;
  localparam int CW = 8, DW = 64, NW = 4;
  localparam int NMAX = (1 << NW) - 1;

  logic          clk = 1'b0, reset, flush, cnt_clear, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_imm, in_opa, in_opb, out_imm, out_opa, out_opb;
  logic [NW-1:0] stall_count, bubble_count;

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cnt_clear(cnt_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_imm(in_imm),
    .in_opa(in_opa), .in_opb(in_opb), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_opa(out_opa), .out_opb(out_opb),
    .stall_count(stall_count), .bubble_count(bubble_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] imm, opa, opb;
  } ent_t;

  // Scoreboard: the instructions held in the stage, oldest first.
  ent_t q[$];
  ent_t last;
  int   m_stall, m_bub;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Set the inputs for one cycle, then let the combinational outputs settle.
  task automatic dfull(bit rs, bit fl, bit cl, bit iv, bit ordy,
                       logic [CW-1:0] c, logic [DW-1:0] im, logic [DW-1:0] a, logic [DW-1:0] b);
    reset = rs; flush = fl; cnt_clear = cl; in_valid = iv; out_ready = ordy;
    in_ctrl = c; in_imm = im; in_opa = a; in_opb = b;
    #1;
  endtask

  task automatic dctl(bit rs, bit fl, bit cl, bit iv, logic [DW-1:0] im, bit ordy);
    dfull(rs, fl, cl, iv, ordy, im[CW-1:0] ^ 8'h3C, im, ~im, im << 3);
  endtask

  task automatic d(bit iv, logic [DW-1:0] im, bit ordy);
    dctl(1'b0, 1'b0, 1'b0, iv, im, ordy);
  endtask

  // Compare every output with the model, then advance the model across the
  // clock edge.
  task automatic cyc();
    bit   ev, acc_e, pop_e;
    ent_t e;
    ev = (q.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2 && !flush));
    chk("out_ctrl", 64'(out_ctrl), ev ? 64'(q[0].ctrl) : 64'd0);
    chk("out_imm", out_imm, last.imm);
    chk("out_opa", out_opa, last.opa);
    chk("out_opb", out_opb, last.opb);
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    chk("bubble_count", 64'(bubble_count), 64'(m_bub));
    @(posedge clk);
    if (reset) begin
      q.delete();
      last = '{default: '0};
      m_stall = 0;
      m_bub = 0;
    end else begin
      acc_e = in_valid && q.size() < 2 && !flush;
      pop_e = ev && out_ready;
      if (cnt_clear) begin
        m_stall = 0;
        m_bub = 0;
      end else begin
        if (ev && !out_ready && m_stall < NMAX) m_stall++;
        if (!ev && m_bub < NMAX) m_bub++;
      end
      if (flush) q.delete();
      else begin
        if (pop_e) void'(q.pop_front());
        if (acc_e) begin
          e.ctrl = in_ctrl; e.imm = in_imm; e.opa = in_opa; e.opb = in_opb;
          q.push_back(e);
        end
      end
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] imm;
    logic          ordy;
    logic          ev, er;
    logic [DW-1:0] eimm;
  } vec_t;
  vec_t vt[6];

  initial begin
    // Back-to-back stream: each row is the input for one cycle and the
    // output expected in that same cycle.
    vt[0] = '{1'b1, 64'd1, 1'b1, 1'b0, 1'b1, 64'd0};
    vt[1] = '{1'b1, 64'd2, 1'b1, 1'b1, 1'b1, 64'd1};
    vt[2] = '{1'b1, 64'd3, 1'b1, 1'b1, 1'b1, 64'd2};
    vt[3] = '{1'b1, 64'd4, 1'b1, 1'b1, 1'b1, 64'd3};
    vt[4] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd4};
    vt[5] = '{1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd4};

    dctl(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete(); last = '{default: '0}; m_stall = 0; m_bub = 0;

    // Reset state, then the vector table.
    d(1'b0, 64'd0, 1'b1);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    cyc();
    for (int i = 0; i < 6; i++) begin
      d(vt[i].iv, vt[i].imm, vt[i].ordy);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vt[i].er));
      chk($sformatf("vec%0d_imm", i), out_imm, vt[i].eimm);
      cyc();
    end
    d(1'b0, 64'd0, 1'b1);
    chk("stream_no_stall", 64'(stall_count), 64'd0);
    cyc();

    // Back-pressure: A sits in main, B goes to the skid, C waits.
    dctl(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1); cyc();
    d(1'b1, 64'hA, 1'b0); cyc();
    d(1'b1, 64'hB, 1'b0); cyc();
    d(1'b1, 64'hC, 1'b0);
    chk("skid_full_ready", 64'(in_ready), 64'd0);
    cyc();
    d(1'b1, 64'hC, 1'b0); cyc();
    d(1'b1, 64'hC, 1'b1); chk("drain_a", out_imm, 64'hA); cyc();
    d(1'b1, 64'hC, 1'b1); chk("drain_b", out_imm, 64'hB); cyc();
    d(1'b0, 64'h0, 1'b1); chk("drain_c", out_imm, 64'hC); cyc();
    d(1'b0, 64'h0, 1'b1);
    chk("stall_cycles", 64'(stall_count), 64'd3);
    cyc();

    // Flush with both entries full and a new instruction offered.
    d(1'b1, 64'hD, 1'b0); cyc();
    d(1'b1, 64'hE, 1'b0); cyc();
    dctl(1'b0, 1'b1, 1'b0, 1'b1, 64'hF, 1'b0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    cyc();
    d(1'b0, 64'h0, 1'b1);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("post_flush_ready", 64'(in_ready), 64'd1);
    cyc();
    repeat (3) begin
      d(1'b0, 64'h0, 1'b1);
      chk("no_F", 64'(out_valid && out_imm == 64'hF), 64'd0);
      cyc();
    end

    // Bubble counting and clear, then stall saturation.
    dctl(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0); cyc();
    repeat (10) begin d(1'b0, 64'd0, 1'b0); cyc(); end
    dctl(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    chk("bubble_10", 64'(bubble_count), 64'd10);
    cyc();
    d(1'b0, 64'd0, 1'b0);
    chk("bubble_cleared", 64'(bubble_count), 64'd0);
    cyc();
    d(1'b1, 64'h55, 1'b0); cyc();
    repeat (20) begin d(1'b0, 64'd0, 1'b0); cyc(); end
    d(1'b0, 64'd0, 1'b1);
    chk("stall_sat", 64'(stall_count), 64'(NMAX));
    cyc();

    // Wide fields pass through unmodified.
    dfull(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 64'h0123_4567_89AB_CDEF,
          64'hDEADBEEF_CAFEF00D, 64'hFEDC_BA98_7654_3210);
    cyc();
    d(1'b0, 64'd0, 1'b1);
    chk("wide_ctrl", 64'(out_ctrl), 64'hA5);
    chk("wide_opa", out_opa, 64'hDEADBEEF_CAFEF00D);
    chk("wide_opb", out_opb, 64'hFEDC_BA98_7654_3210);
    cyc();

    // Reset wins over flush while the skid is full.
    d(1'b1, 64'h61, 1'b0); cyc();
    d(1'b1, 64'h62, 1'b0); cyc();
    dctl(1'b1, 1'b1, 1'b0, 1'b1, 64'h63, 1'b0); cyc();
    d(1'b0, 64'd0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_opa", out_opa, 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    cyc();
    repeat (4) begin d(1'b0, 64'd0, 1'b1); cyc(); end

    // Random traffic with occasional flushes and counter clears.
    for (int i = 0; i < 400; i++) begin
      dfull(1'b0, ($urandom % 16) == 0, ($urandom % 40) == 0, 1'($urandom), 1'($urandom),
            8'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised, elastic ID/EX pipeline stage. Carries decoded control, extended immediate and two register operands from decode to execute.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from EX never drops or duplicates an instruction.
- Supports synchronous flush (branch/exception squash) and inserts control-safe bubbles.
- Provides saturating stall and bubble counters for performance monitoring.

Parameters:
- CTRL_W, 6, control bundle width; default packing is {reg_write, mem_write, mem_to_reg, alu_src, alu_control[1:0]}.
- DATA_W, 32, width of the immediate and of each operand.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held instructions.
- cnt_clear  input  1  synchronous clear of both counters.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept; equals !skid_valid && !flush (combinational).
- in_ctrl  input  CTRL_W  decoded control bundle.
- in_imm  input  DATA_W  extended immediate.
- in_opa  input  DATA_W  operand A.
- in_opb  input  DATA_W  operand B.
- out_valid  output  1  the main register holds a valid instruction.
- out_ready  input  1  execute consumes the instruction.
- out_ctrl  output  CTRL_W  control bundle; forced to all-zero whenever out_valid=0.
- out_imm  output  DATA_W  immediate from the main register.
- out_opa  output  DATA_W  operand A from the main register.
- out_opb  output  DATA_W  operand B from the main register.
- stall_count  output  CNT_W  cycles with out_valid && !out_ready.
- bubble_count  output  CNT_W  cycles with !out_valid.

Behaviour:
- Storage: a main register (drives the outputs) and a skid register, each holding {valid, ctrl, imm, opa, opb}. Invariant: skid_valid implies main_valid.
- Accept condition: acc = in_valid && in_ready. Pop condition: pop = out_valid && out_ready.
- Latency: an accepted instruction appears on out_* the next cycle, unless it is queued behind a held entry.
- Update rules, main empty:
  - acc: main <= in.
- Update rules, main full, skid empty:
  - pop && acc: main <= in.
  - pop && !acc: main_valid <= 0.
  - !pop && acc: skid <= in.
  - !pop && !acc: hold.
- Update rules, skid full (in_ready=0):
  - pop: main <= skid, skid_valid <= 0.
  - !pop: hold.
- Ordering: strictly FIFO. No instruction is duplicated or reordered.
- Throughput: one instruction per cycle sustained while out_ready=1.
- Flush (not in reset):
  - Next cycle: main_valid=0, skid_valid=0; out_ctrl therefore reads 0.
  - Any in_valid presented in the flush cycle is not accepted (in_ready=0).
  - An out_ready asserted in the flush cycle still counts as a pop for the consumer.
  - in_ready returns to 1 the cycle after flush.
- Bubble gating: out_ctrl = main_valid ? main_ctrl : 0. out_imm, out_opa and out_opb hold their last value while invalid.
- Reset:
  - Dominates flush and cnt_clear.
  - All valid bits, control, data and counters go to 0.
  - Outputs after reset: out_valid=0, out_ctrl=0, out_imm=out_opa=out_opb=0, in_ready=1, stall_count=bubble_count=0.
  - Reset mid-stall discards both entries.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
  - cnt_clear zeroes both counters next cycle; a qualifying event in the clear cycle is not counted.
  - The flush cycle itself counts under whichever condition holds that cycle.

Test Plan:
- Reset, then 4 back-to-back accepts (imm=1,2,3,4) with out_ready=1 -> out_valid from cycle 1; imm sequence 1,2,3,4 in consecutive cycles; stall_count=0.
- Accept A (imm=0xA), hold out_ready=0, present B (imm=0xB) -> B goes to skid and in_ready drops to 0; C is held off. Raise out_ready -> A, B, C emerge in order; stall_count equals the number of cycles with out_ready low.
- Main and skid both full, assert flush with in_valid=1 (imm=0xF) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xF never appears on the outputs.
- Idle 10 cycles after reset, then pulse cnt_clear -> bubble_count reads 10 before the clear and 0 the cycle after. With CNT_W=4, a 20-cycle stall saturates stall_count at 15.
- With CTRL_W=8 and DATA_W=64, pass ctrl=0xA5 and opa=0xDEADBEEF_CAFEF00D -> values appear unmodified on the outputs; out_ctrl=0 on every invalid cycle.
- Assert reset while skid is full and flush=1 in the same cycle -> all outputs at reset values next cycle; no stale instruction emerges afterwards.
